// File: rtl/display_driver_bcm_serializer.sv
// BCM bit-plane serializer for HUB75-style RGB matrix rows.
// Walks all planes of one row MSB first: fetch, shift, latch, display.
module display_driver_bcm_serializer #(
  parameter int segments    = 1,
  parameter int bitwidth    = 8,
  parameter int columns     = 64,
  parameter int pipe_length = 1,
  parameter int base_cycles = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(columns)-1:0]      addr,
  input  logic [bitwidth*3*segments-1:0]  pixel,
  output logic [3*segments-1:0]           rgb,
  output logic                            rgb_valid,
  output logic                            latch,
  output logic                            blank
);

  localparam int CH = 3 * segments;
  localparam int AW = $clog2(columns);
  localparam int PW = (bitwidth > 1) ? $clog2(bitwidth) : 1;
  localparam int DW = $clog2((base_cycles << (bitwidth - 1)) + 1);
  localparam int FW = $clog2(pipe_length + 2);

  localparam logic [AW-1:0] LAST_COL  = AW'(columns - 1);
  localparam logic [PW-1:0] TOP_PLANE = PW'(bitwidth - 1);
  localparam logic [FW-1:0] FLUSH_END = FW'(pipe_length);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    FLUSH,
    LATCH,
    DISPLAY
  } state_t;

  state_t                  state;
  logic [PW-1:0]           plane;
  logic [DW-1:0]           dcnt;
  logic [FW-1:0]           fcnt;
  logic [pipe_length-1:0]  vp;
  logic                    issue;
  logic [DW-1:0]           disp_len;
  logic [CH-1:0]           sel;
  logic [bitwidth-1:0]     chan;

  assign issue    = (state == SHIFT);
  assign disp_len = DW'((base_cycles << plane) - 1);

  // Pick the current plane's bit out of every colour channel.
  always_comb begin
    sel  = '0;
    chan = '0;
    for (int g = 0; g < CH; g++) begin
      chan   = pixel[g*bitwidth +: bitwidth];
      sel[g] = chan[plane];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      plane     <= TOP_PLANE;
      dcnt      <= '0;
      fcnt      <= '0;
      vp        <= '0;
      rgb       <= '0;
      rgb_valid <= 1'b0;
      latch     <= 1'b0;
      blank     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done  <= 1'b0;
      latch <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        blank     <= 1'b1;
        busy      <= 1'b0;
        vp        <= '0;
        rgb_valid <= 1'b0;
      end else begin
        vp[0] <= issue;
        for (int i = 1; i < pipe_length; i++) begin
          vp[i] <= vp[i-1];
        end
        rgb_valid <= vp[pipe_length-1];
        if (vp[pipe_length-1]) begin
          rgb <= sel;
        end
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= SHIFT;
              plane <= TOP_PLANE;
              addr  <= '0;
              busy  <= 1'b1;
            end
          end
          SHIFT: begin
            if (addr == LAST_COL) begin
              state <= FLUSH;
              fcnt  <= '0;
            end else begin
              addr <= addr + AW'(1);
            end
          end
          // Wait until the last column's bit has left the pipe.
          FLUSH: begin
            if (fcnt == FLUSH_END) begin
              state <= LATCH;
              latch <= 1'b1;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
          LATCH: begin
            state <= DISPLAY;
            blank <= 1'b0;
            dcnt  <= disp_len;
          end
          DISPLAY: begin
            if (dcnt == '0) begin
              blank <= 1'b1;
              if (plane == '0) begin
                state <= IDLE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= SHIFT;
                plane <= plane - PW'(1);
                addr  <= '0;
              end
            end else begin
              dcnt <= dcnt - DW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
